alu_vector_checker: RTL and testbench

Self-checking response engine for the single-cycle ALU. It accepts packed test vectors over a valid/ready stream, drives the ALU operands and control, and compares the ALU's Result/ALUFlags against the expected values. It tallies pass/fail counts and records the first failing vector, so ALU regression runs in hardware (FPGA bring-up) or in simulation without per-vector waveform inspection.

---
 rtl/alu_vector_checker.sv | 167 ++++++++++++++++
 tb/tb_alu_vector_checker.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_vector_checker.sv
// Self-checking response engine for the single-cycle ALU: streams packed vectors
// into the ALU, compares Result/flags one cycle later, and tallies pass/fail.
module alu_vector_checker #(
    parameter int unsigned NUM_VECTORS = 20,
    parameter int unsigned CNT_W       = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [101:0]     vec_data,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [1:0]       alu_control,
    input  logic [31:0]      alu_result,
    input  logic [3:0]       alu_flags,
    output logic             busy,
    output logic             done,
    output logic             all_pass,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             first_fail_valid,
    output logic [35:0]      first_fail_got
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
    logic [CNT_W-1:0] stage_idx_q, stage_idx_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
    logic             ff_valid_q, ff_valid_d;
    logic [35:0]      ff_got_q, ff_got_d;
    logic             stage_valid_q, stage_valid_d;
    logic [31:0]      alu_a_q, alu_a_d;
    logic [31:0]      alu_b_q, alu_b_d;
    logic [1:0]       alu_ctrl_q, alu_ctrl_d;
    logic [31:0]      exp_result_q, exp_result_d;
    logic [3:0]       exp_flags_q, exp_flags_d;
    logic             xfer;
    logic             match;

    assign vec_ready = (state_q == S_RUN);
    assign xfer      = vec_valid && vec_ready;
    assign match     = (alu_result == exp_result_q) && (alu_flags == exp_flags_q);

    always_comb begin
        state_d       = state_q;
        vec_idx_d     = vec_idx_q;
        stage_idx_d   = stage_idx_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        ff_idx_d      = ff_idx_q;
        ff_valid_d    = ff_valid_q;
        ff_got_d      = ff_got_q;
        stage_valid_d = 1'b0;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_ctrl_d    = alu_ctrl_q;
        exp_result_d  = exp_result_q;
        exp_flags_d   = exp_flags_q;

        // The staged vector is judged on the edge after it was accepted.
        if (stage_valid_q) begin
            if (match) begin
                pass_d = pass_q + ONE;
            end else begin
                fail_d = fail_q + ONE;
                if (!ff_valid_q) begin
                    ff_valid_d = 1'b1;
                    ff_idx_d   = stage_idx_q;
                    ff_got_d   = {alu_result, alu_flags};
                end
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RUN;
                    vec_idx_d  = '0;
                    pass_d     = '0;
                    fail_d     = '0;
                    ff_idx_d   = '0;
                    ff_valid_d = 1'b0;
                    ff_got_d   = '0;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    alu_ctrl_d    = vec_data[101:100];
                    alu_a_d       = vec_data[99:68];
                    alu_b_d       = vec_data[67:36];
                    exp_result_d  = vec_data[35:4];
                    exp_flags_d   = vec_data[3:0];
                    stage_valid_d = 1'b1;
                    stage_idx_d   = vec_idx_q;
                    vec_idx_d     = vec_idx_q + ONE;
                    if (vec_idx_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            vec_idx_q     <= '0;
            stage_idx_q   <= '0;
            pass_q        <= '0;
            fail_q        <= '0;
            ff_idx_q      <= '0;
            ff_valid_q    <= 1'b0;
            ff_got_q      <= '0;
            stage_valid_q <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_ctrl_q    <= '0;
            exp_result_q  <= '0;
            exp_flags_q   <= '0;
        end else begin
            state_q       <= state_d;
            vec_idx_q     <= vec_idx_d;
            stage_idx_q   <= stage_idx_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            ff_idx_q      <= ff_idx_d;
            ff_valid_q    <= ff_valid_d;
            ff_got_q      <= ff_got_d;
            stage_valid_q <= stage_valid_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_ctrl_q    <= alu_ctrl_d;
            exp_result_q  <= exp_result_d;
            exp_flags_q   <= exp_flags_d;
        end
    end

    assign alu_a            = alu_a_q;
    assign alu_b            = alu_b_q;
    assign alu_control      = alu_ctrl_q;
    assign busy             = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done             = (state_q == S_DONE);
    assign all_pass         = (state_q == S_DONE) && (fail_q == '0);
    assign pass_count       = pass_q;
    assign fail_count       = fail_q;
    assign first_fail_idx   = ff_idx_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_got   = ff_got_q;

endmodule

// File: tb/tb_alu_vector_checker.sv
// Bench for alu_vector_checker: behavioural ALU plant, directed vector table,
// corrupted/gapped/aborted runs and randomized runs against a per-vector scoreboard.
module tb_alu_vector_checker;

    localparam int NV = 20;

    typedef struct {
        logic [1:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] er;
        logic [3:0]  ef;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          vec_valid;
    logic          vec_ready;
    logic [101:0]  vec_data;
    logic [31:0]   alu_a, alu_b, alu_result;
    logic [1:0]    alu_control;
    logic [3:0]    alu_flags;
    logic          busy, done, all_pass, first_fail_valid;
    logic [9:0]    pass_count, fail_count, first_fail_idx;
    logic [35:0]   first_fail_got;

    int n_cmp = 0;
    int n_err = 0;

    vec_t dir_tab[NV];
    vec_t vecs[NV];

    int          m_pass, m_fail, m_ffi;
    bit          m_ffv;
    logic [35:0] m_ffg;

    always #5 clk = ~clk;

    alu_vector_checker #(.NUM_VECTORS(NV), .CNT_W(10)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .busy(busy), .done(done), .all_pass(all_pass),
        .pass_count(pass_count), .fail_count(fail_count),
        .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid),
        .first_fail_got(first_fail_got)
    );

    // Arithmetic definition of the ALU: {result, N, Z, C, V}.
    function automatic logic [35:0] alu_ref(input logic [1:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        cy, ov;
        s  = '0;
        cy = 1'b0;
        ov = 1'b0;
        case (c)
            2'b00: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                cy = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            2'b01: begin
                s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r  = s[31:0];
                cy = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
        return {r, r[31], (r == 32'd0), cy, ov};
    endfunction

    assign {alu_result, alu_flags} = alu_ref(alu_control, alu_a, alu_b);

    function automatic logic [101:0] pack(input vec_t v);
        return {v.c, v.a, v.b, v.er, v.ef};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_compare(input bit ok, input int idx, input logic [35:0] got);
        if (ok) m_pass++;
        else begin
            m_fail++;
            if (!m_ffv) begin
                m_ffv = 1'b1;
                m_ffi = idx;
                m_ffg = got;
            end
        end
    endtask

    // gap_mode: 0 back-to-back, 1 valid pattern 1,0,0,1, 2 random gaps.
    task automatic run(input int gap_mode, input bit mid_start, input int abort_after);
        int          idx, cyc, pend_idx;
        bit          pend, pend_ok, v, rdy;
        logic [35:0] pend_got;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_clr_pass", pass_count, 0);
        chk("start_clr_fail", fail_count, 0);
        chk("start_clr_ffv", first_fail_valid, 0);
        chk("start_clr_done", done, 0);
        m_pass = 0; m_fail = 0; m_ffv = 1'b0; m_ffi = 0; m_ffg = '0;
        idx = 0; cyc = 0; pend = 1'b0; pend_idx = 0; pend_ok = 1'b0; pend_got = '0;
        while (idx < NV && cyc < 400) begin
            @(negedge clk);
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: v = ($urandom_range(3) != 0);
            endcase
            vec_valid = v;
            vec_data  = pack(vecs[idx]);
            start     = mid_start && (cyc == 5);
            rdy       = vec_ready;
            chk("ready_in_run", vec_ready, 1);
            @(posedge clk); #1;
            start = 1'b0;
            if (pend) model_compare(pend_ok, pend_idx, pend_got);
            pend = v && rdy;
            if (pend) begin
                pend_got = alu_ref(vecs[idx].c, vecs[idx].a, vecs[idx].b);
                pend_ok  = (pend_got == {vecs[idx].er, vecs[idx].ef});
                pend_idx = idx;
                idx++;
            end
            chk("run_pass", pass_count, m_pass);
            chk("run_fail", fail_count, m_fail);
            cyc++;
            if (abort_after > 0 && idx == abort_after) return;
        end
        if (idx < NV) chk("run_timeout", idx, NV);
        @(negedge clk);
        vec_valid = 1'b0;
        chk("drain_busy", busy, 1);
        chk("drain_not_ready", vec_ready, 0);
        chk("drain_not_done", done, 0);
        @(posedge clk); #1;
        if (pend) model_compare(pend_ok, pend_idx, pend_got);
        chk("done", done, 1);
        chk("done_not_busy", busy, 0);
        chk("done_not_ready", vec_ready, 0);
        chk("final_pass", pass_count, m_pass);
        chk("final_fail", fail_count, m_fail);
        chk("final_sum", pass_count + fail_count, NV);
        chk("all_pass", all_pass, (m_fail == 0));
        chk("ff_valid", first_fail_valid, m_ffv);
        if (m_ffv) begin
            chk("ff_idx", first_fail_idx, m_ffi);
            chk("ff_got", first_fail_got, m_ffg);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("done_held", done, 1);
        chk("pass_held", pass_count, m_pass);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        dir_tab[0]  = '{2'b00, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b0110};
        dir_tab[1]  = '{2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
        dir_tab[2]  = '{2'b00, 32'h00000002, 32'h00000003, 32'h00000005, 4'b0000};
        dir_tab[3]  = '{2'b01, 32'h00000005, 32'h00000003, 32'h00000002, 4'b0010};
        dir_tab[4]  = '{2'b01, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000};
        dir_tab[5]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000};
        dir_tab[6]  = '{2'b11, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 4'b1000};
        dir_tab[7]  = '{2'b10, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 4'b0100};
        dir_tab[8]  = '{2'b01, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
        dir_tab[9]  = '{2'b01, 32'h00000007, 32'h00000007, 32'h00000000, 4'b0110};
        dir_tab[10] = '{2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 4'b0111};
        dir_tab[11] = '{2'b11, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0100};
        dir_tab[12] = '{2'b10, 32'h12345678, 32'hFF00FF00, 32'h12005600, 4'b0000};
        dir_tab[13] = '{2'b11, 32'h12345678, 32'h0000FFFF, 32'h1234FFFF, 4'b0000};
        dir_tab[14] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1010};
        dir_tab[15] = '{2'b01, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000};
        dir_tab[16] = '{2'b00, 32'h40000000, 32'h40000000, 32'h80000000, 4'b1001};
        dir_tab[17] = '{2'b10, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 4'b0100};
        dir_tab[18] = '{2'b11, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 4'b1000};
        dir_tab[19] = '{2'b00, 32'h0000FFFF, 32'h00000001, 32'h00010000, 4'b0000};

        reset_n = 1'b0; start = 1'b0; vec_valid = 1'b0; vec_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", vec_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_all_pass", all_pass, 0);
        chk("rst_pass", pass_count, 0);
        chk("rst_fail", fail_count, 0);
        chk("rst_ffv", first_fail_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_start_busy", busy, 0);

        // Directed table, back-to-back.
        for (int i = 0; i < NV; i++) vecs[i] = dir_tab[i];
        run(0, 1'b0, 0);
        chk("dir_pass20", pass_count, 20);
        chk("dir_all_pass", all_pass, 1);

        // Corrupted vectors 5 and 9; the first failure must stay at 5.
        vecs[5].er = 32'h00000000;
        vecs[9].er = 32'h00000001;
        run(0, 1'b0, 0);
        chk("bad_fail2", fail_count, 2);
        chk("bad_ff_idx", first_fail_idx, 5);
        chk("bad_ff_got", first_fail_got, {32'hFFFFFFFF, 4'b1000});
        chk("bad_all_pass", all_pass, 0);

        // Start pulsed mid-run is ignored; start from DONE repeats identically.
        run(0, 1'b1, 0);
        chk("midstart_fail2", fail_count, 2);
        run(0, 1'b0, 0);
        chk("rerun_fail2", fail_count, 2);
        chk("rerun_pass18", pass_count, 18);

        // Gap pattern 1,0,0,1 on the clean table.
        for (int i = 0; i < NV; i++) vecs[i] = dir_tab[i];
        run(1, 1'b0, 0);
        chk("gap_pass20", pass_count, 20);

        // Asynchronous reset after 7 transfers.
        run(0, 1'b0, 7);
        #3;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", vec_ready, 0);
        chk("abort_pass", pass_count, 0);
        chk("abort_alu_a", alu_a, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        vec_valid = 1'b0;
        reset_n   = 1'b1;
        run(0, 1'b0, 0);
        chk("post_abort_pass20", pass_count, 20);

        // Randomized runs with corrupted expectations and random gaps.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NV; i++) begin
                logic [35:0] e;
                vecs[i].c = 2'($urandom_range(3));
                vecs[i].a = ($urandom_range(3) == 0) ? 32'h7FFFFFFF : $urandom;
                vecs[i].b = ($urandom_range(3) == 0) ? 32'h80000000 : $urandom;
                e = alu_ref(vecs[i].c, vecs[i].a, vecs[i].b);
                if ($urandom_range(4) == 0) e[$urandom_range(35)] ^= 1'b1;
                {vecs[i].er, vecs[i].ef} = e;
            end
            run(2, 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
